// File: rtl/rr_onehot_arb.sv
// Purpose: round-robin arbiter, registered one-hot grant with binary index (optional RR_ONEHOT_ARB_CHK_EN self-check adds err).
// Latency: 1 cycle from req to gnt_vld; back-to-back grants on handshake with no bubble.
// Backpressure: grant held stable while gnt_vld & !gnt_rdy; pointer advances only on handshake.
module rr_onehot_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    input  logic          gnt_rdy,
    output logic [IW-1:0] gnt_idx
`ifdef RR_ONEHOT_ARB_CHK_EN
   ,output logic          err
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic          hs;
    logic          win_found;
    logic [IW-1:0] win_idx;

    // Handshake only exists while a grant is being offered; rdy in IDLE is ignored.
    always_comb begin
        hs = (state_q == HOLD) && gnt_rdy;
    end

    // Pointer moves one past the accepted winner so the scan for a same-cycle reload already uses it.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Round-robin scan: lowest offset from ptr_d with a set request wins (descending loop keeps the nearest).
    always_comb begin
        int pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr_d) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[IW'(pos)]) begin
                win_found = 1'b1;
                win_idx   = IW'(pos);
            end
        end
    end

    // Next-state and grant load: IDLE loads on any request; HOLD keeps the grant until handshake.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = HOLD;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (win_found) begin
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        idx_d          = win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any grant in flight without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = (state_q == HOLD);
    assign gnt_idx = idx_q;

`ifdef RR_ONEHOT_ARB_CHK_EN
    logic err_q;
    logic bad_grant;

    // A valid grant must have exactly one bit set and that bit must match the index.
    always_comb begin
        bad_grant = 1'b0;
        if (gnt_vld) begin
            bad_grant = ($countones(gnt_q) != 1) || (gnt_q != (N'(1) << idx_q));
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bad_grant) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Purpose: self-checking bench for rr_onehot_arb (N=4): directed scenarios plus randomized traffic against a reference model.
// Latency: model advances once per rising edge; outputs are sampled on the falling edge.
// Backpressure: gnt_rdy is driven both directed and randomly to exercise hold and back-to-back paths.
module tb_rr_onehot_arb;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_vld;
    logic          gnt_rdy;
    logic [IW-1:0] gnt_idx;
`ifdef RR_ONEHOT_ARB_CHK_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: whether a grant is outstanding, who holds it, and the round-robin pointer.
    int m_vld = 0;
    int m_idx = 0;
    int m_ptr = 0;

    rr_onehot_arb #(.N(N), .IW(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_rdy (gnt_rdy),
        .gnt_idx (gnt_idx)
`ifdef RR_ONEHOT_ARB_CHK_EN
       ,.err     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assert property (@(posedge clk) gnt_vld |-> ($countones(gnt) == 1));

    // First requester at or after pointer p, walking upward and wrapping.
    function automatic int rr_pick(int p, logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_vld != 0) g[m_idx] = 1'b1;
        return g;
    endfunction

    // One clock: apply the arbitration rules to the inputs present at the edge, then wait to the sample point.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_vld = 0; m_idx = 0; m_ptr = 0;
        end else if (m_vld == 0) begin
            if (req != '0) begin
                m_idx = rr_pick(m_ptr, req);
                m_vld = 1;
            end
        end else if (gnt_rdy) begin
            m_ptr = (m_idx + 1) % N;
            if (req != '0) begin
                m_idx = rr_pick(m_ptr, req);
            end else begin
                m_vld = 0;
                m_idx = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; gnt_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d gnt=%b vld=%b idx=%0d want gnt=0000 vld=0 idx=0", c, gnt, gnt_vld, gnt_idx);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant gnt=%b vld=%b idx=%0d want gnt=0001 vld=1 idx=0", gnt, gnt_vld, gnt_idx);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_seq [4];
        int count [N];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) count[i] = 0;
        req = 4'b1111; gnt_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            count[gnt_idx]++;
            checks++;
            if (gnt !== exp_seq[c] || gnt_vld !== 1'b1 || gnt !== (4'b0001 << gnt_idx)) begin
                errors++;
                $display("FAIL fairness_seq step=%0d gnt=%b vld=%b idx=%0d want gnt=%b vld=1", c, gnt, gnt_vld, gnt_idx, exp_seq[c]);
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (count[i] != 1) begin
                errors++;
                $display("FAIL fairness_count req=%0d granted=%0d want 1", i, count[i]);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL fairness_drain gnt=%b vld=%b idx=%0d want gnt=0000 vld=0 idx=0", gnt, gnt_vld, gnt_idx);
        end
    endtask

    task automatic test_backpressure();
        req = 4'b0100; gnt_rdy = 1'b0;
        tick();
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (gnt !== 4'b0100 || gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d gnt=%b vld=%b idx=%0d want gnt=0100 vld=1 idx=2", c, gnt, gnt_vld, gnt_idx);
            end
            if (c < 4) tick();
        end
        gnt_rdy = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL backpressure_release gnt=%b vld=%b idx=%0d want gnt=0000 vld=0 idx=0", gnt, gnt_vld, gnt_idx);
        end
    endtask

    task automatic test_wrap();
        // Pointer is 3 here: last accepted grant was requester 2.
        req = 4'b0011; gnt_rdy = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first gnt=%b idx=%0d vld=%b want gnt=0001 idx=0 vld=1", gnt, gnt_idx, gnt_vld);
        end
        gnt_rdy = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second gnt=%b idx=%0d vld=%b want gnt=0010 idx=1 vld=1", gnt, gnt_idx, gnt_vld);
        end
        req = 4'b0000;
        tick();
        gnt_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        req = 4'b1000; gnt_rdy = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL midhold_load gnt=%b vld=%b want gnt=1000 vld=1", gnt, gnt_vld);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL midhold_reset gnt=%b vld=%b idx=%0d want gnt=0000 vld=0 idx=0", gnt, gnt_vld, gnt_idx);
        end
        rst = 1'b0; req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL midhold_ptr_cleared gnt=%b vld=%b idx=%0d want gnt=0001 vld=1 idx=0", gnt, gnt_vld, gnt_idx);
        end
`ifdef RR_ONEHOT_ARB_CHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_directed err=%b want 0", err);
        end
`endif
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 49) == 0);
            req     = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            gnt_rdy = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (gnt !== m_gnt() || gnt_vld !== (m_vld != 0) || gnt_idx !== IW'(m_idx)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_model cyc=%0d gnt=%b vld=%b idx=%0d want gnt=%b vld=%0d idx=%0d",
                             c, gnt, gnt_vld, gnt_idx, m_gnt(), m_vld, m_idx);
            end
        end
        rst = 1'b0; req = 4'b0000; gnt_rdy = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt_vld !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL random_drain gnt=%b vld=%b want gnt=0000 vld=0", gnt, gnt_vld);
        end
`ifdef RR_ONEHOT_ARB_CHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_random err=%b want 0", err);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; req = '0; gnt_rdy = 1'b0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
